// File: rtl/box_pkg.sv
// Shared constants and helpers for the three-row box-filter line feeder.
package box_pkg;

    localparam int BOX_DATA_W  = 8;

    // Line-store word layout: {row n-1, row n-2}
    localparam int BOX_WORD_LO = 0;
    localparam int BOX_WORD_HI = 1;

    function automatic int box_col_w(input int img_width);
        return (img_width > 1) ? $clog2(img_width) : 1;
    endfunction

    function automatic int box_row_w(input int img_height);
        return (img_height > 1) ? $clog2(img_height) : 1;
    endfunction

endpackage

// File: rtl/box_line_ram.sv
// Simple dual-port line store: one write port, one registered read port with read-enable.
module box_line_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 16,
    parameter int AW    = 9
) (
    input  logic             i_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately never reset; rd_data holds while rd_en is low.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/box_line_feeder.sv
// Raster pixel stream in, vertically aligned (n-2, n-1, n) pixel triples out.
// Optional macro BOX_EDGE_REPLICATE_EN: emit a triple for every pixel, replicating the top edge.
module box_line_feeder
    import box_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int DATA_W     = BOX_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_pixel,
    input  logic              i_pixel_valid,
    output logic              o_pixel_ack,
    output logic [DATA_W-1:0] o_pixel_1,
    output logic [DATA_W-1:0] o_pixel_2,
    output logic [DATA_W-1:0] o_pixel_3,
    output logic              o_pixel_valid,
    input  logic              i_pixel_ack
);

    localparam int CW = box_col_w(IMG_WIDTH);
    localparam int RW = box_row_w(IMG_HEIGHT);
    localparam int WW = 2 * DATA_W;

    // Handshake: a transfer happens on a rising edge where valid and ack are both high;
    // valid never waits for ack, and the pipeline advances only when its output slot is free or taken.
    logic              adv;
    logic              in_xfer;
    logic              wr_en;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;

    logic              s1_v;
    logic [CW-1:0]     s1_col;
    logic [DATA_W-1:0] s1_pixel;
`ifdef BOX_EDGE_REPLICATE_EN
    logic              s1_row0;
    logic              s1_row1;
`else
    logic              s1_primed;
`endif

    logic [WW-1:0]     rd_word;
    logic [WW-1:0]     wr_word;
    logic [DATA_W-1:0] rd_hi;
    logic [DATA_W-1:0] rd_lo;

    logic [DATA_W-1:0] nxt_1;
    logic [DATA_W-1:0] nxt_2;
    logic [DATA_W-1:0] nxt_3;
    logic              nxt_valid;

    assign adv         = ~o_pixel_valid | i_pixel_ack;
    assign o_pixel_ack = adv;
    assign in_xfer     = i_pixel_valid & adv;
    assign wr_en       = s1_v & adv;

    assign rd_hi = rd_word[BOX_WORD_HI*DATA_W +: DATA_W];
    assign rd_lo = rd_word[BOX_WORD_LO*DATA_W +: DATA_W];

    always_comb begin
        wr_word = '0;
        wr_word[BOX_WORD_HI*DATA_W +: DATA_W] = s1_pixel;
        wr_word[BOX_WORD_LO*DATA_W +: DATA_W] = rd_hi;
    end

    box_line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (WW),
        .AW    (CW)
    ) u_line_ram (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr (s1_col),
        .wr_data (wr_word),
        .rd_en   (in_xfer),
        .rd_addr (col),
        .rd_data (rd_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col <= '0;
            row <= '0;
        end else if (in_xfer) begin
            if (col == CW'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v <= 1'b0;
        end else if (adv) begin
            s1_v <= in_xfer;
        end
    end

    always_ff @(posedge i_clk) begin
        if (in_xfer) begin
            s1_col   <= col;
            s1_pixel <= i_pixel;
`ifdef BOX_EDGE_REPLICATE_EN
            s1_row0  <= (row == RW'(0));
            s1_row1  <= (row == RW'(1));
`else
            s1_primed <= (row >= RW'(2));
`endif
        end
    end

    // Top-edge rows reuse the freshest available line instead of stale store contents.
    always_comb begin
        nxt_1 = rd_lo;
        nxt_2 = rd_hi;
        nxt_3 = s1_pixel;
`ifdef BOX_EDGE_REPLICATE_EN
        nxt_valid = 1'b1;
        if (s1_row0) begin
            nxt_1 = s1_pixel;
            nxt_2 = s1_pixel;
        end else if (s1_row1) begin
            nxt_1 = rd_hi;
        end
`else
        nxt_valid = s1_primed;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pixel_valid <= 1'b0;
            o_pixel_1     <= '0;
            o_pixel_2     <= '0;
            o_pixel_3     <= '0;
        end else if (adv) begin
            if (s1_v) begin
                o_pixel_valid <= nxt_valid;
                o_pixel_1     <= nxt_1;
                o_pixel_2     <= nxt_2;
                o_pixel_3     <= nxt_3;
            end else begin
                o_pixel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_box_line_feeder.sv
// Scoreboard bench for box_line_feeder on a 4x4 frame; honours BOX_EDGE_REPLICATE_EN.
module tb_box_line_feeder;

    localparam int W = 4;
    localparam int H = 4;
`ifdef BOX_EDGE_REPLICATE_EN
    localparam int PER_FRAME = W * H;
    localparam int PER_PRIME = 2 * W;
`else
    localparam int PER_FRAME = W * (H - 2);
    localparam int PER_PRIME = 0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_pixel = '0;
    logic       i_pixel_valid = 1'b0;
    logic       o_pixel_ack;
    logic [7:0] o_pixel_1;
    logic [7:0] o_pixel_2;
    logic [7:0] o_pixel_3;
    logic       o_pixel_valid;
    logic       i_pixel_ack = 1'b1;

    logic [23:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int out_cnt = 0;
    int b_row = 0;
    int b_col = 0;
    int c0 = 0;
    bit rnd_done = 1'b0;

    box_line_feeder #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (8)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_pixel       (i_pixel),
        .i_pixel_valid (i_pixel_valid),
        .o_pixel_ack   (o_pixel_ack),
        .o_pixel_1     (o_pixel_1),
        .o_pixel_2     (o_pixel_2),
        .o_pixel_3     (o_pixel_3),
        .o_pixel_valid (o_pixel_valid),
        .i_pixel_ack   (i_pixel_ack)
    );

    // clock
    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(16 * r + c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int r, input int c);
`ifdef BOX_EDGE_REPLICATE_EN
        if (r == 0) exp_q.push_back({pix(r, c), pix(r, c), pix(r, c)});
        else if (r == 1) exp_q.push_back({pix(0, c), pix(0, c), pix(r, c)});
        else exp_q.push_back({pix(r - 2, c), pix(r - 1, c), pix(r, c)});
`else
        if (r >= 2) exp_q.push_back({pix(r - 2, c), pix(r - 1, c), pix(r, c)});
`endif
    endtask

    // driver: offer the next raster pixel until accepted
    task automatic send_next();
        int waited = 0;
        logic acc = 1'b0;
        i_pixel = pix(b_row, b_col);
        i_pixel_valid = 1'b1;
        while (!acc) begin
            @(negedge i_clk);
            acc = o_pixel_ack;
            @(posedge i_clk);
            #1;
            waited++;
            if (!acc && waited >= 200) begin
                chk("accept_timeout", 32'(waited), 32'(0));
                break;
            end
        end
        i_pixel_valid = 1'b0;
        if (acc) begin
            push_exp(b_row, b_col);
            if (b_col == W - 1) begin
                b_col = 0;
                b_row = (b_row == H - 1) ? 0 : b_row + 1;
            end else begin
                b_col++;
            end
        end
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send_next();
    endtask

    task automatic idle(input int n);
        i_pixel_valid = 1'b0;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic rst_pulse();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_q.delete();
        b_row = 0;
        b_col = 0;
    endtask

    initial begin
        // monitor / scoreboard
        fork
            forever begin
                @(negedge i_clk);
                if (o_pixel_valid === 1'b1) begin
                    if (i_pixel_ack) begin
                        out_cnt++;
                        chk("have_exp", 32'(exp_q.size() != 0), 32'(1));
                        if (exp_q.size() != 0)
                            chk("triple", {8'h0, o_pixel_1, o_pixel_2, o_pixel_3}, {8'h0, exp_q.pop_front()});
                    end else begin
                        chk("stall_ack", 32'(o_pixel_ack), 32'(0));
                        if (exp_q.size() != 0)
                            chk("held", {8'h0, o_pixel_1, o_pixel_2, o_pixel_3}, {8'h0, exp_q[0]});
                    end
                end
            end
        join_none

        // reset state, with downstream ack low so o_pixel_ack must come from ~o_pixel_valid
        i_pixel_ack = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_valid", 32'(o_pixel_valid), 32'(0));
        chk("rst_ack", 32'(o_pixel_ack), 32'(1));
        chk("rst_triple", {8'h0, o_pixel_1, o_pixel_2, o_pixel_3}, 32'(0));
        @(posedge i_clk);
        #1;
        i_pixel_ack = 1'b1;

        // frame 1: prime, then first-output latency
        c0 = out_cnt;
        send_n(2 * W);
        idle(3);
        chk("prime_cnt", 32'(out_cnt - c0), 32'(PER_PRIME));
        send_next();
        @(negedge i_clk);
        chk("lat_t1", 32'(o_pixel_valid), 32'(0));
        @(negedge i_clk);
        chk("lat_t2", 32'(o_pixel_valid), 32'(1));
        @(posedge i_clk);
        #1;
        send_n(2 * W - 1);
        idle(4);
        chk("frame1_cnt", 32'(out_cnt - c0), 32'(PER_FRAME));

        // frame 2: continuous, priming rows checked separately
        c0 = out_cnt;
        send_n(2 * W);
        idle(3);
        chk("frame2_prime", 32'(out_cnt - c0), 32'(PER_PRIME));
        send_n(2 * W);
        idle(4);
        chk("frame2_cnt", 32'(out_cnt - c0), 32'(PER_FRAME));

        // frame 3: continuous, 5-cycle downstream stall in row 3
        c0 = out_cnt;
        send_n(3 * W);
        fork
            send_n(W);
            begin
                @(posedge i_clk);
                #1;
                i_pixel_ack = 1'b0;
                repeat (5) @(posedge i_clk);
                #1;
                i_pixel_ack = 1'b1;
            end
        join
        idle(4);
        chk("frame3_cnt", 32'(out_cnt - c0), 32'(PER_FRAME));

        // frames 4-5: random input gaps and random downstream ack
        c0 = out_cnt;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 2 * W * H; i++) begin
                    if ($urandom_range(0, 2) == 0) idle(1);
                    send_next();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge i_clk);
                    #1;
                    i_pixel_ack = ($urandom_range(0, 3) != 0);
                end
                i_pixel_ack = 1'b1;
            end
        join
        idle(6);
        chk("rand_cnt", 32'(out_cnt - c0), 32'(2 * PER_FRAME));
        chk("rand_drain", 32'(exp_q.size()), 32'(0));

        // reset mid-line after row 2 col 1, then a fresh frame must re-prime
        send_n(2 * W + 2);
        rst_pulse();
        @(negedge i_clk);
        chk("midrst_valid", 32'(o_pixel_valid), 32'(0));
        chk("midrst_ack", 32'(o_pixel_ack), 32'(1));
        @(posedge i_clk);
        #1;
        c0 = out_cnt;
        send_n(W * H);
        idle(4);
        chk("postrst_cnt", 32'(out_cnt - c0), 32'(PER_FRAME));
        chk("final_drain", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
